f2c_mem_ctrl: RTL

Fabric-side initiator for the F2C (Fabric-To-Core) memory port of a gpc_4t tile. It accepts host read/write commands, such as a loader or debug agent filling I_MEM/D_MEM, and issues WR/RD requests on the F2C request lines. It tracks outstanding reads, collects RD_RSP responses into a buffered return queue and flags protocol errors. It sits on the ring/fabric side, wired directly to a tile's F2C_Req*Q502H inputs and F2C_Rsp*Q500H outputs.

---
 rtl/lotr_pkg.sv | 23 ++
 rtl/f2c_sync_fifo.sv | 67 ++++++
 rtl/f2c_mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lotr_pkg.sv
// -----------------------------------------------------------------------------
// lotr_pkg
// Shared types for the lotr tile fabric.
//   t_opcode      : F2C request/response opcode (RD, WR, RD_RSP).
//   t_f2c_rd_rsp  : one buffered read response {address, data}.
//   F2C_RSP_DEPTH_DEFAULT : default response FIFO depth / read credit count.
// -----------------------------------------------------------------------------
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'b00,
        WR     = 2'b01,
        RD_RSP = 2'b10
    } t_opcode;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
    } t_f2c_rd_rsp;

    localparam int F2C_RSP_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/f2c_sync_fifo.sv
// -----------------------------------------------------------------------------
// f2c_sync_fifo
// Single-clock FIFO with combinational head read (popData shows the oldest
// entry whenever empty=0). DEPTH must be a power of 2 so the pointers wrap
// naturally.
//   QClk, RstQnnnL : clock, async active-low reset
//   push, pushData : write one entry (ignored when full and not popping)
//   pop,  popData  : remove the head entry (ignored when empty)
//   full, empty, count : occupancy status, count in 0..DEPTH
// -----------------------------------------------------------------------------
module f2c_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    QClk,
    input  logic                    RstQnnnL,
    input  logic                    push,
    input  logic [WIDTH-1:0]        pushData,
    input  logic                    pop,
    output logic [WIDTH-1:0]        popData,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    // A full FIFO can still accept a push in the cycle its head is popped.
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            // NOTE: the storage array is reset as well, so the head read seen
            // by the host is 0 straight out of reset rather than unknown.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/f2c_mem_ctrl.sv
// -----------------------------------------------------------------------------
// f2c_mem_ctrl
// Fabric-side initiator for a gpc_4t tile's F2C memory port. Host commands are
// registered onto the F2C request lines one cycle after acceptance. Reads are
// tracked in an expected-address queue; RD_RSP responses are checked against it
// and buffered in a response FIFO that the host drains. Protocol errors are
// reported through sticky flags.
//   QClk, RstQnnnL          : clock, async active-low reset
//   Cmd*                    : host command handshake (WR is fire-and-forget,
//                             RD needs a read credit)
//   F2C_Req*Q502H           : request to tile, registered, zero when idle
//   F2C_Rsp*Q500H           : response from tile, cannot be stalled
//   RdRsp*                  : buffered read responses to the host
//   Busy                    : reads outstanding or request in flight
//   ErrClear, Err*          : sticky error flags and their clear
// -----------------------------------------------------------------------------
module f2c_mem_ctrl
    import lotr_pkg::*;
#(
    parameter int RSP_DEPTH   = F2C_RSP_DEPTH_DEFAULT,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic [31:0] CmdAddress,
    input  logic [31:0] CmdData,
    output logic        F2C_ReqValidQ502H,
    output t_opcode     F2C_ReqOpcodeQ502H,
    output logic [31:0] F2C_ReqAddressQ502H,
    output logic [31:0] F2C_ReqDataQ502H,
    input  logic        F2C_RspValidQ500H,
    input  t_opcode     F2C_RspOpcodeQ500H,
    input  logic [31:0] F2C_RspAddressQ500H,
    input  logic [31:0] F2C_RspDataQ500H,
    output logic        RdRspValid,
    input  logic        RdRspReady,
    output logic [31:0] RdRspAddress,
    output logic [31:0] RdRspData,
    output logic        Busy,
    input  logic        ErrClear,
    output logic        ErrMismatch,
    output logic        ErrUnexpected,
    output logic        ErrTimeout
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] outCnt;
    logic [CW-1:0] rspCnt;
    logic [CW:0]   occupancy;
    logic          credit;
    logic          cmdAccept;
    logic          rdAccept;
    logic          rspAccept;
    logic          rspUnexpected;
    logic          rspMismatch;
    logic          rspPop;

    logic [31:0]   expAddress;
    logic          expFull;
    logic          expEmpty;
    logic [CW-1:0] expCnt;

    t_f2c_rd_rsp   rspPushData;
    t_f2c_rd_rsp   rspHead;
    logic          rspFull;
    logic          rspEmpty;

    logic [TW-1:0] toCnt;
    logic          toHit;

    // Every outstanding read owns a FIFO slot, so a response can always be
    // buffered without back-pressuring the tile.
    assign occupancy = {1'b0, outCnt} + {1'b0, rspCnt};
    assign credit    = (occupancy < (CW+1)'(RSP_DEPTH));
    assign CmdReady  = CmdWrite ? 1'b1 : credit;
    assign cmdAccept = CmdValid && CmdReady;
    assign rdAccept  = cmdAccept && !CmdWrite;

    assign rspAccept     = F2C_RspValidQ500H && (F2C_RspOpcodeQ500H == RD_RSP) && (outCnt != '0);
    assign rspUnexpected = F2C_RspValidQ500H && !rspAccept;
    assign rspMismatch   = rspAccept && (expAddress != F2C_RspAddressQ500H);
    assign rspPop        = !rspEmpty && RdRspReady;
    assign rspPushData   = '{address: F2C_RspAddressQ500H, data: F2C_RspDataQ500H};

    assign toHit = (outCnt != '0) && !rspAccept && (toCnt == TW'(TIMEOUT_CYC - 1));

    assign RdRspValid   = !rspEmpty;
    assign RdRspAddress = rspHead.address;
    assign RdRspData    = rspHead.data;
    assign Busy         = (outCnt != '0) || F2C_ReqValidQ502H;

    // Request register: carries the accepted command for exactly one cycle.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            F2C_ReqValidQ502H   <= 1'b0;
            F2C_ReqOpcodeQ502H  <= RD;
            F2C_ReqAddressQ502H <= '0;
            F2C_ReqDataQ502H    <= '0;
        end else if (cmdAccept) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            F2C_ReqValidQ502H   <= 1'b1;
            F2C_ReqOpcodeQ502H  <= CmdWrite ? WR : RD;
            F2C_ReqAddressQ502H <= CmdAddress;
            F2C_ReqDataQ502H    <= CmdWrite ? CmdData : '0;
        end else begin
            F2C_ReqValidQ502H   <= 1'b0;
            F2C_ReqOpcodeQ502H  <= RD;
            F2C_ReqAddressQ502H <= '0;
            F2C_ReqDataQ502H    <= '0;
        end
    end

    // Outstanding reads and response timeout.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            outCnt <= '0;
            toCnt  <= '0;
        end else begin
            case ({rdAccept, rspAccept})
                2'b10:   outCnt <= outCnt + 1'b1;
                2'b01:   outCnt <= outCnt - 1'b1;
                default: outCnt <= outCnt;
            endcase
            if ((outCnt == '0) || rspAccept) begin
                toCnt <= '0;
            end else if (toCnt != TW'(TIMEOUT_CYC)) begin
                toCnt <= toCnt + 1'b1;
            end
        end
    end

    // Sticky errors: a new event in the same cycle overrides ErrClear.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            ErrMismatch   <= 1'b0;
            ErrUnexpected <= 1'b0;
            ErrTimeout    <= 1'b0;
        end else begin
            ErrMismatch   <= (ErrMismatch   && !ErrClear) || rspMismatch;
            ErrUnexpected <= (ErrUnexpected && !ErrClear) || rspUnexpected;
            ErrTimeout    <= (ErrTimeout    && !ErrClear) || toHit;
        end
    end

    f2c_sync_fifo #(
        .WIDTH (32),
        .DEPTH (RSP_DEPTH)
    ) u_expQ (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .push     (rdAccept),
        .pushData (CmdAddress),
        .pop      (rspAccept),
        .popData  (expAddress),
        .full     (expFull),
        .empty    (expEmpty),
        .count    (expCnt)
    );

    f2c_sync_fifo #(
        .WIDTH ($bits(t_f2c_rd_rsp)),
        .DEPTH (RSP_DEPTH)
    ) u_rspQ (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .push     (rspAccept),
        .pushData (rspPushData),
        .pop      (rspPop),
        .popData  (rspHead),
        .full     (rspFull),
        .empty    (rspEmpty),
        .count    (rspCnt)
    );

    a_rspNoOverflow: assert property (@(posedge QClk) disable iff (!RstQnnnL)
        rspAccept |-> !rspFull);
    a_expNoOverflow: assert property (@(posedge QClk) disable iff (!RstQnnnL)
        rdAccept |-> !expFull);
    a_expTracksOut: assert property (@(posedge QClk) disable iff (!RstQnnnL)
        (expCnt == outCnt) && (expEmpty == (outCnt == '0)));

endmodule
